instruct_mem_pipe: RTL

Parametrised, synchronous-read successor to the single-cycle instruction ROM, intended for the pipelined RV32I core. It accepts fetch requests through a valid/ready handshake and returns instructions after a configurable 1- or 2-cycle latency. A programming write port lets a boot loader fill the memory at run time. After reset, a built-in clear engine fills the whole array with a fill word before fetches are accepted.

---
 rtl/instruct_mem_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instruct_mem_pipe.sv
// rtl/instruct_mem_pipe.sv - pipelined synchronous-read instruction memory with clear engine and boot write port
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, adds Instr_Parity_Err)
module instruct_mem_pipe #(
    parameter int          MEM_SIZE     = 16384,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] FILL_WORD    = 32'h00000013
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Fetch_Req,
    input  logic [31:0] Program_Count,
    output logic        Fetch_Ready,
    input  logic        Fetch_Stall,
    input  logic        Fetch_Flush,
    output logic        Instr_Valid,
    output logic [31:0] Instruction,
    output logic        Instr_Fault,
`ifdef IMEM_PARITY_EN
    output logic        Instr_Parity_Err,
`endif
    input  logic        Prog_Wr_En,
    input  logic [31:0] Prog_Addr,
    input  logic [31:0] Prog_Data,
    input  logic [3:0]  Prog_Byte_En,
    output logic        Mem_Ready
);

    localparam int          ADDR_SIZE  = $clog2(MEM_SIZE);
    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_SIZE * 4);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   clear_ptr_q;
    logic [31:0]            mem [MEM_SIZE];
`ifdef IMEM_PARITY_EN
    logic                   mem_par [MEM_SIZE];
`endif

    logic                   run;
    logic                   prog_hit;
    logic [ADDR_SIZE-1:0]   prog_idx;
    logic                   mem_we;
    logic [ADDR_SIZE-1:0]   mem_widx;
    logic [31:0]            mem_wdata;

    logic                   accept;
    logic [ADDR_SIZE-1:0]   fetch_idx;
    logic                   addr_fault;
    logic                   word_bad;

    logic                   s1_valid, s1_fault;
    logic [31:0]            s1_instr;
    logic                   out_valid, out_fault;
    logic [31:0]            out_instr;
`ifdef IMEM_PARITY_EN
    logic                   s1_perr, out_perr;
`endif

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                clear_ptr_q <= clear_ptr_q + ADDR_SIZE'(1);
        end
    end

    // MEM_SIZE is a power of two, so an all-ones pointer marks the last word.
    always_comb begin
        state_d     = state_q;
        Mem_Ready   = 1'b0;
        Fetch_Ready = 1'b0;
        case (state_q)
            CLEAR: if (&clear_ptr_q) state_d = RUN;
            RUN: begin
                Mem_Ready   = 1'b1;
                Fetch_Ready = !Fetch_Stall && !Prog_Wr_En;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign run      = (state_q == RUN);
    assign prog_idx = Prog_Addr[ADDR_SIZE+1:2];
    assign prog_hit = run && Prog_Wr_En && (Prog_Addr < BYTE_LIMIT);

    // Byte enables are merged against the stored word so parity covers the final value.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = clear_ptr_q;
        mem_wdata = FILL_WORD;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (prog_hit) begin
            mem_we    = 1'b1;
            mem_widx  = prog_idx;
            mem_wdata = mem[prog_idx];
            for (int b = 0; b < 4; b++)
                if (Prog_Byte_En[b])
                    mem_wdata[8*b +: 8] = Prog_Data[8*b +: 8];
        end
    end

    always_ff @(posedge Clk_Core) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
`ifdef IMEM_PARITY_EN
            mem_par[mem_widx] <= ^mem_wdata;
`endif
        end
    end

    assign accept     = Fetch_Req && Fetch_Ready;
    assign fetch_idx  = Program_Count[ADDR_SIZE+1:2];
    assign addr_fault = (|Program_Count[1:0]) || (Program_Count >= BYTE_LIMIT);
`ifdef IMEM_PARITY_EN
    assign word_bad   = !addr_fault && ((^mem[fetch_idx]) != mem_par[fetch_idx]);
`else
    assign word_bad   = 1'b0;
`endif

    // A stalled cycle never accepts, so flush-with-stall still empties stage 1.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            s1_valid <= 1'b0;
            s1_fault <= 1'b0;
            s1_instr <= '0;
`ifdef IMEM_PARITY_EN
            s1_perr  <= 1'b0;
`endif
        end else begin
            if (Fetch_Flush || !Fetch_Stall)
                s1_valid <= accept;
            if (accept) begin
                s1_fault <= addr_fault || word_bad;
                s1_instr <= (addr_fault || word_bad) ? 32'h0 : mem[fetch_idx];
`ifdef IMEM_PARITY_EN
                s1_perr  <= word_bad;
`endif
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        s2_valid, s2_fault;
            logic [31:0] s2_instr;
`ifdef IMEM_PARITY_EN
            logic        s2_perr;
`endif
            always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
                if (!Rst_Core_N) begin
                    s2_valid <= 1'b0;
                    s2_fault <= 1'b0;
                    s2_instr <= '0;
`ifdef IMEM_PARITY_EN
                    s2_perr  <= 1'b0;
`endif
                end else if (Fetch_Flush) begin
                    s2_valid <= 1'b0;
                end else if (!Fetch_Stall) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_fault <= s1_fault;
                        s2_instr <= s1_instr;
`ifdef IMEM_PARITY_EN
                        s2_perr  <= s1_perr;
`endif
                    end
                end
            end
            assign out_valid = s2_valid;
            assign out_fault = s2_fault;
            assign out_instr = s2_instr;
`ifdef IMEM_PARITY_EN
            assign out_perr  = s2_perr;
`endif
        end else begin : g_lat1
            assign out_valid = s1_valid;
            assign out_fault = s1_fault;
            assign out_instr = s1_instr;
`ifdef IMEM_PARITY_EN
            assign out_perr  = s1_perr;
`endif
        end
    endgenerate

    assign Instr_Valid = out_valid;
    assign Instruction = out_instr;
    assign Instr_Fault = out_fault;
`ifdef IMEM_PARITY_EN
    assign Instr_Parity_Err = out_valid && out_perr;
`endif

endmodule
